// File: rtl/framebuffer_write_arbiter_pkg.sv
// Shared framebuffer constants, output-slot type and saturating counter helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package framebuffer_write_arbiter_pkg;

    localparam int         FRAMEBUFFER_ADDR_SIZE = 15;
    localparam int         FRAMEBUFFER_SIZE      = 64000;
    localparam logic [3:0] FB_TRANSPARENT        = 4'b0000;
    localparam int         FB_ARB_MAX_REQ        = 8;
    localparam int         FB_AW                 = FRAMEBUFFER_ADDR_SIZE + 1;

    // One registered write-port slot
    typedef struct packed {
        logic             en;
        logic [FB_AW-1:0] addr;
        logic [3:0]       data;
    } wr_slot_t;

    // 16-bit counter add that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] val, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, val} + {14'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/fb_arb_picker.sv
// Two-grant rotating-priority picker: first valid from ptr gets A, the next gets B.
// Latency: purely combinational.
// Backpressure: B is withheld when its address matches A's; that requester simply retries.
module fb_arb_picker #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 16,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]    valid,
    input  logic [PW-1:0]         ptr,
    input  logic [NUM_REQ*AW-1:0] addr,
    output logic [NUM_REQ-1:0]    grant_a,
    output logic [NUM_REQ-1:0]    grant_b,
    output logic [PW-1:0]         idx_a,
    output logic [PW-1:0]         idx_b,
    output logic                  found_a,
    output logic                  found_b
);

    logic [AW-1:0] addr_arr [NUM_REQ];
    logic [PW:0]   pos;
    logic [PW-1:0] cur;
    logic          scan_done;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = addr[g*AW +: AW];
    end

    // Walk the requesters once in rotating order; B is the very next valid after A or nothing
    always_comb begin
        found_a   = 1'b0;
        found_b   = 1'b0;
        idx_a     = '0;
        idx_b     = '0;
        pos       = '0;
        cur       = '0;
        scan_done = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(NUM_REQ)) begin
                pos = pos - (PW+1)'(NUM_REQ);
            end
            cur = pos[PW-1:0];
            if (valid[cur] && !scan_done) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = cur;
                end else begin
                    if (addr_arr[cur] != addr_arr[idx_a]) begin
                        found_b = 1'b1;
                        idx_b   = cur;
                    end
                    scan_done = 1'b1;
                end
            end
        end
    end

    // Expand the chosen indices into one-hot grant vectors
    always_comb begin
        grant_a = '0;
        grant_b = '0;
        if (found_a) grant_a[idx_a] = 1'b1;
        if (found_b) grant_b[idx_b] = 1'b1;
    end

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Shares the two back-buffer write ports among NUM_REQ pixel producers, 2 pixels/cycle.
// Latency: 1 cycle from acceptance (valid & ready) to write-port presentation.
// Backpressure: req_ready is a combinational grant; none while fb_resetting or reset is active.
module framebuffer_write_arbiter
    import framebuffer_write_arbiter_pkg::*;
#(
    parameter int         NUM_REQ     = 4,
    parameter logic [3:0] TRANSPARENT = FB_TRANSPARENT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fb_resetting,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*FB_AW-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]     req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [FB_AW-1:0]         addr_wr1,
    output logic [FB_AW-1:0]         addr_wr2,
    output logic [3:0]               data_wr1,
    output logic [3:0]               data_wr2,
    output logic                     wr1_en,
    output logic                     wr2_en,
    output logic [15:0]              written_count,
    output logic [15:0]              drop_count
);

    localparam int             AW       = FB_AW;
    localparam int             PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW-1:0]  FB_LIMIT = AW'(FRAMEBUFFER_SIZE);

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      last_idx;
    logic [NUM_REQ-1:0] valid_eff;
    logic [NUM_REQ-1:0] grant_a;
    logic [NUM_REQ-1:0] grant_b;
    logic [PW-1:0]      idx_a;
    logic [PW-1:0]      idx_b;
    logic               found_a;
    logic               found_b;
    logic [AW-1:0]      addr_a;
    logic [AW-1:0]      addr_b;
    logic [3:0]         data_a;
    logic [3:0]         data_b;
    logic               ok_a;
    logic               ok_b;
    logic               oor_a;
    logic               oor_b;
    wr_slot_t           slot1_q;
    wr_slot_t           slot2_q;
    logic [1:0]         supp_q;
    logic               fb_resetting_q;
    logic               fb_rise;
    logic [2:0]         wr_inc;
    logic [2:0]         drop_inc;

    // No grants at all while the buffer is being cleared or the block is in reset
    assign valid_eff = req_valid & {NUM_REQ{reset & ~fb_resetting}};

    fb_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .AW      (AW),
        .PW      (PW)
    ) u_picker (
        .valid   (valid_eff),
        .ptr     (rr_ptr),
        .addr    (req_addr),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .idx_a   (idx_a),
        .idx_b   (idx_b),
        .found_a (found_a),
        .found_b (found_b)
    );

    assign req_ready = grant_a | grant_b;
    assign addr_a    = req_addr[idx_a*AW +: AW];
    assign addr_b    = req_addr[idx_b*AW +: AW];
    assign data_a    = req_data[idx_a*4 +: 4];
    assign data_b    = req_data[idx_b*4 +: 4];

    // Transparent pixels are swallowed silently; opaque pixels past the buffer are counted drops
    assign ok_a  = found_a && (data_a != TRANSPARENT) && (addr_a <  FB_LIMIT);
    assign ok_b  = found_b && (data_b != TRANSPARENT) && (addr_b <  FB_LIMIT);
    assign oor_a = found_a && (data_a != TRANSPARENT) && (addr_a >= FB_LIMIT);
    assign oor_b = found_b && (data_b != TRANSPARENT) && (addr_b >= FB_LIMIT);

    assign last_idx = found_b ? idx_b : idx_a;

    // Pointer, output slots and reset-window bookkeeping
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr         <= '0;
            slot1_q        <= '0;
            slot2_q        <= '0;
            supp_q         <= '0;
            fb_resetting_q <= 1'b0;
        end else begin
            fb_resetting_q <= fb_resetting;
            slot1_q.en     <= ok_a;
            slot2_q.en     <= ok_b;
            if (found_a) begin
                slot1_q.addr <= addr_a;
                slot1_q.data <= data_a;
                rr_ptr       <= (last_idx == PW'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
            end
            if (found_b) begin
                slot2_q.addr <= addr_b;
                slot2_q.data <= data_b;
            end
            // A suppressed write always coincides with the clear edge, so it is
            // counted one cycle later to survive the clear.
            supp_q <= {1'b0, slot1_q.en & fb_resetting} + {1'b0, slot2_q.en & fb_resetting};
        end
    end

    // framebuffer_master owns the ports while clearing, so registered writes are masked then
    assign wr1_en   = slot1_q.en & ~fb_resetting;
    assign wr2_en   = slot2_q.en & ~fb_resetting;
    assign addr_wr1 = slot1_q.addr;
    assign addr_wr2 = slot2_q.addr;
    assign data_wr1 = slot1_q.data;
    assign data_wr2 = slot2_q.data;

    assign fb_rise  = fb_resetting & ~fb_resetting_q;
    assign wr_inc   = {2'b00, wr1_en} + {2'b00, wr2_en};
    assign drop_inc = {1'b0, supp_q} + {2'b00, oor_a} + {2'b00, oor_b};

    // Statistics counters: cleared on each new clear window, otherwise saturating
    always_ff @(posedge clock) begin
        if (!reset || fb_rise) begin
            written_count <= '0;
            drop_count    <= '0;
        end else begin
            written_count <= sat_add16(written_count, wr_inc);
            drop_count    <= sat_add16(drop_count, drop_inc);
        end
    end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Bench for framebuffer_write_arbiter: directed vector table, then random traffic vs a queue model.
// Latency: checks grants in-cycle and write ports one cycle after acceptance.
// Backpressure: requesters hold valid/addr/data until the model predicts acceptance.
module tb_framebuffer_write_arbiter;
    import framebuffer_write_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = FB_AW;

    logic             clock = 1'b0;
    logic             reset;
    logic             fb_resetting;
    logic [N-1:0]     req_valid;
    logic [N*AW-1:0]  req_addr;
    logic [N*4-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [AW-1:0]    addr_wr1, addr_wr2;
    logic [3:0]       data_wr1, data_wr2;
    logic             wr1_en, wr2_en;
    logic [15:0]      written_count, drop_count;

    logic [N-1:0]     d_valid;
    logic [AW-1:0]    d_addr [N];
    logic [3:0]       d_data [N];

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model state
    int m_ptr, m_w, m_dr, m_supp;
    int m_a [2];
    int m_d [2];
    bit m_en [2];
    bit m_prev;

    always #5 clock = ~clock;

    assign req_valid = d_valid;
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = d_addr[g];
        assign req_data[g*4 +: 4]   = d_data[g];
    end

    framebuffer_write_arbiter #(.NUM_REQ(N), .TRANSPARENT(FB_TRANSPARENT)) dut (
        .clock         (clock),
        .reset         (reset),
        .fb_resetting  (fb_resetting),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .addr_wr1      (addr_wr1),
        .addr_wr2      (addr_wr2),
        .data_wr1      (data_wr1),
        .data_wr2      (data_wr2),
        .wr1_en        (wr1_en),
        .wr2_en        (wr2_en),
        .written_count (written_count),
        .drop_count    (drop_count)
    );

    typedef struct {
        logic        rst;
        logic        fbr;
        logic [3:0]  v;
        logic [63:0] a;
        logic [15:0] d;
        logic [3:0]  rdy;
        logic        e1;
        logic        e2;
        int          a1, d1, a2, d2, w, dr;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic rst, input logic fbr, input logic [3:0] v,
                                input logic [63:0] a, input logic [15:0] d,
                                input logic [3:0] rdy, input logic e1, input logic e2,
                                input int a1, input int d1, input int a2, input int d2,
                                input int w, input int dr);
        vec_t r;
        r.rst = rst; r.fbr = fbr; r.v = v; r.a = a; r.d = d; r.rdy = rdy;
        r.e1 = e1; r.e2 = e2; r.a1 = a1; r.d1 = d1; r.a2 = a2; r.d2 = d2;
        r.w = w; r.dr = dr;
        return r;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s @%0d: got %0d, expected %0d", name, row, act, want);
    endtask

    task automatic check_all(input string tag, input int row, input logic [3:0] rdy,
                             input logic e1, input logic e2, input int a1, input int d1,
                             input int a2, input int d2, input int w, input int dr);
        check({tag, ".req_ready"},     row, 32'(req_ready),     32'(rdy));
        check({tag, ".wr1_en"},        row, 32'(wr1_en),        32'(e1));
        check({tag, ".wr2_en"},        row, 32'(wr2_en),        32'(e2));
        check({tag, ".addr_wr1"},      row, 32'(addr_wr1),      a1);
        check({tag, ".data_wr1"},      row, 32'(data_wr1),      d1);
        check({tag, ".addr_wr2"},      row, 32'(addr_wr2),      a2);
        check({tag, ".data_wr2"},      row, 32'(data_wr2),      d2);
        check({tag, ".written_count"}, row, 32'(written_count), w);
        check({tag, ".drop_count"},    row, 32'(drop_count),    dr);
    endtask

    // Spec rule: list valid requesters in rotating order from the pointer; first -> A,
    // second -> B unless it targets A's address.
    task automatic model_pick(output int ga, output int gb);
        int order[$];
        ga = -1;
        gb = -1;
        if (reset && !fb_resetting) begin
            for (int k = 0; k < N; k++)
                if (d_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
            if (order.size() > 0) ga = order[0];
            if (order.size() > 1 && d_addr[order[1]] != d_addr[ga]) gb = order[1];
        end
    endtask

    function automatic logic [3:0] ready_of(input int ga, input int gb);
        logic [3:0] r;
        r = '0;
        if (ga >= 0) r[ga] = 1'b1;
        if (gb >= 0) r[gb] = 1'b1;
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_advance();
        int ga, gb, pres, supp, oor, g;
        bit rise;
        model_pick(ga, gb);
        if (!reset) begin
            m_ptr = 0; m_w = 0; m_dr = 0; m_supp = 0; m_prev = 0;
            for (int p = 0; p < 2; p++) begin m_en[p] = 0; m_a[p] = 0; m_d[p] = 0; end
        end else begin
            pres = 0; supp = 0; oor = 0;
            for (int p = 0; p < 2; p++) begin
                if (m_en[p] && !fb_resetting) pres++;
                if (m_en[p] && fb_resetting)  supp++;
            end
            for (int p = 0; p < 2; p++) begin
                g = (p == 0) ? ga : gb;
                m_en[p] = 0;
                if (g >= 0) begin
                    m_a[p] = int'(d_addr[g]);
                    m_d[p] = int'(d_data[g]);
                    if (d_data[g] != FB_TRANSPARENT) begin
                        if (int'(d_addr[g]) < FRAMEBUFFER_SIZE) m_en[p] = 1;
                        else oor++;
                    end
                end
            end
            rise = fb_resetting && !m_prev;
            if (rise) begin
                m_w = 0; m_dr = 0;
            end else begin
                m_w  = sat(m_w + pres);
                m_dr = sat(m_dr + m_supp + oor);
            end
            m_supp = supp;
            m_prev = fb_resetting;
            if (ga >= 0) m_ptr = (((gb >= 0) ? gb : ga) + 1) % N;
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int ga, gb;
        logic [3:0] acc;

        reset = 1'b0; fb_resetting = 1'b0; d_valid = '0;
        for (int i = 0; i < N; i++) begin d_addr[i] = '0; d_data[i] = '0; end
        tick();
        tick();

        //              rst fbr v        addrs {a3,a2,a1,a0}                      data         rdy      e1 e2  a1     d1 a2  d2 w   dr
        tbl[0]  = mk(0, 0, 4'b1111, 64'd0,                                           16'h0000, 4'b0000, 0, 0, 0,     0, 0,  0, 0,  0);
        tbl[1]  = mk(1, 0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd100},                  16'h0005, 4'b0001, 0, 0, 0,     0, 0,  0, 0,  0);
        tbl[2]  = mk(1, 0, 4'b1000, {16'd200, 16'd0, 16'd0, 16'd0},                  16'h6000, 4'b1000, 1, 0, 100,   5, 0,  0, 0,  0);
        tbl[3]  = mk(1, 0, 4'b1111, {16'd13, 16'd12, 16'd11, 16'd10},                16'h4321, 4'b0011, 1, 0, 200,   6, 0,  0, 1,  0);
        tbl[4]  = mk(1, 0, 4'b1111, {16'd13, 16'd12, 16'd11, 16'd10},                16'h4321, 4'b1100, 1, 1, 10,    1, 11, 2, 2,  0);
        tbl[5]  = mk(1, 0, 4'b1111, {16'd13, 16'd12, 16'd11, 16'd10},                16'h4321, 4'b0011, 1, 1, 12,    3, 13, 4, 4,  0);
        tbl[6]  = mk(1, 0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd20},                   16'h0009, 4'b0001, 1, 1, 10,    1, 11, 2, 6,  0);
        tbl[7]  = mk(1, 0, 4'b0110, {16'd0, 16'd42, 16'd42, 16'd0},                  16'h0870, 4'b0010, 1, 0, 20,    9, 11, 2, 8,  0);
        tbl[8]  = mk(1, 0, 4'b0100, {16'd0, 16'd42, 16'd0, 16'd0},                   16'h0800, 4'b0100, 1, 0, 42,    7, 11, 2, 9,  0);
        tbl[9]  = mk(1, 0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd30},                   16'h0000, 4'b0001, 1, 0, 42,    8, 11, 2, 10, 0);
        tbl[10] = mk(1, 0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd64000},                16'h0003, 4'b0001, 0, 0, 30,    0, 11, 2, 11, 0);
        tbl[11] = mk(1, 0, 4'b0000, 64'd0,                                           16'h0000, 4'b0000, 0, 0, 64000, 3, 11, 2, 11, 1);
        tbl[12] = mk(1, 0, 4'b0011, {16'd0, 16'd0, 16'd51, 16'd50},                  16'h0021, 4'b0011, 0, 0, 64000, 3, 11, 2, 11, 1);
        tbl[13] = mk(1, 1, 4'b0100, {16'd0, 16'd60, 16'd0, 16'd0},                   16'h0300, 4'b0000, 0, 0, 51,    2, 50, 1, 11, 1);
        tbl[14] = mk(1, 1, 4'b0100, {16'd0, 16'd60, 16'd0, 16'd0},                   16'h0300, 4'b0000, 0, 0, 51,    2, 50, 1, 0,  0);
        tbl[15] = mk(1, 0, 4'b0100, {16'd0, 16'd60, 16'd0, 16'd0},                   16'h0300, 4'b0100, 0, 0, 51,    2, 50, 1, 0,  2);
        tbl[16] = mk(1, 0, 4'b1111, {16'd73, 16'd72, 16'd71, 16'd70},                16'h4321, 4'b1001, 1, 0, 60,    3, 50, 1, 0,  2);
        tbl[17] = mk(0, 0, 4'b1111, {16'd73, 16'd72, 16'd71, 16'd70},                16'h4321, 4'b0000, 1, 1, 73,    4, 70, 1, 1,  2);
        tbl[18] = mk(1, 0, 4'b1111, {16'd73, 16'd72, 16'd71, 16'd70},                16'h4321, 4'b0011, 0, 0, 0,     0, 0,  0, 0,  0);
        tbl[19] = mk(1, 0, 4'b0000, 64'd0,                                           16'h0000, 4'b0000, 1, 1, 70,    1, 71, 2, 0,  0);
        tbl[20] = mk(1, 0, 4'b0000, 64'd0,                                           16'h0000, 4'b0000, 0, 0, 70,    1, 71, 2, 2,  0);

        for (int r = 0; r < 21; r++) begin
            reset        = tbl[r].rst;
            fb_resetting = tbl[r].fbr;
            d_valid      = tbl[r].v;
            for (int i = 0; i < N; i++) begin
                d_addr[i] = tbl[r].a[i*16 +: 16];
                d_data[i] = tbl[r].d[i*4 +: 4];
            end
            #1;
            check_all("vec", r, tbl[r].rdy, tbl[r].e1, tbl[r].e2, tbl[r].a1, tbl[r].d1,
                      tbl[r].a2, tbl[r].d2, tbl[r].w, tbl[r].dr);
            tick();
        end

        // Random traffic: requesters hold each pixel until accepted
        d_valid = '0;
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            if (fb_resetting) fb_resetting = ($urandom_range(0, 2) != 0);
            else              fb_resetting = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < N; i++) begin
                if (!d_valid[i] && $urandom_range(0, 1) == 1) begin
                    d_valid[i] = 1'b1;
                    if ($urandom_range(0, 7) == 0) d_addr[i] = 16'($urandom_range(63995, 64005));
                    else                           d_addr[i] = 16'($urandom_range(0, 7));
                    d_data[i] = 4'($urandom_range(0, 15));
                end
            end
            #1;
            model_pick(ga, gb);
            acc = ready_of(ga, gb);
            check_all("rnd", c, acc, m_en[0] && !fb_resetting, m_en[1] && !fb_resetting,
                      m_a[0], m_d[0], m_a[1], m_d[1], m_w, m_dr);
            tick();
            d_valid = d_valid & ~acc;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/framebuffer_write_arbiter.md
# framebuffer_write_arbiter

- Shares the two back-buffer write ports of `framebuffer_master` among `NUM_REQ` pixel producers, such as the road, sprite and HUD renderers.
- Grants up to two pixels per cycle using rotating priority.
- Drops transparent, out-of-range and reset-window pixels.
- Drives `addr_wr1/2`, `data_wr1/2` and `wr1_en/wr2_en` from a registered output stage.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TRANSPARENT`, default 4'b0000: colour index that is accepted but never written.
- `FRAMEBUFFER_SIZE` and `FRAMEBUFFER_ADDR_SIZE` come from `params.vh`.

Ports (`AW` = `FRAMEBUFFER_ADDR_SIZE+1`):
- `clock`  in  1: single clock domain for the whole block.
- `reset`  in  1: synchronous, active-low.
- `fb_resetting`  in  1: from `framebuffer_master`; high while the back buffer is being cleared.
- `req_valid`  in  `NUM_REQ`: pixel offered; must be held, with addr and data stable, until accepted.
- `req_addr`  in  `NUM_REQ*AW`: packed; requester i occupies `[i*AW +: AW]`.
- `req_data`  in  `NUM_REQ*4`: packed colour index; requester i occupies `[i*4 +: 4]`.
- `req_ready`  out  `NUM_REQ`: combinational grant. A transfer occurs when `valid & ready`.
- `addr_wr1`, `addr_wr2`  out  `AW`: registered write addresses.
- `data_wr1`, `data_wr2`  out  4: registered write data.
- `wr1_en`, `wr2_en`  out  1: registered write enables.
- `written_count`  out  16: pixels written since the last rising edge of `fb_resetting`; saturates at 16'hFFFF.
- `drop_count`  out  16: pixels accepted but dropped for out-of-range address or reset window; saturates.

## Operation
- Rotating pointer `rr_ptr` (`$clog2(NUM_REQ)` bits) selects the highest-priority requester.

Grant selection, each cycle:
- Grant A: scan indices `rr_ptr`, `rr_ptr+1`, … (mod `NUM_REQ`). The first `req_valid` found is granted port 1.
- Grant B: continue the scan after grant A. The next valid requester is granted port 2.
- Grant B is withheld if its address equals grant A's address. That requester stays not-ready and retries next cycle; no same-address dual-port collisions are ever issued.
- When `fb_resetting` = 1, no grants are issued: `req_ready` = 0 and `rr_ptr` holds.

Pointer update:
- After any grant, `rr_ptr` <= (index of last granted) + 1, mod `NUM_REQ`.
- With no grant, `rr_ptr` is unchanged.

Per accepted pixel, the output-stage enable is set as follows:
- `data == TRANSPARENT`: enable 0, no counter change.
- `addr >= FRAMEBUFFER_SIZE`: enable 0, `drop_count` + 1.
- Otherwise: enable 1, `written_count` + 1 when it lands.

Reset-window handling:
- If `fb_resetting` is high in the cycle a registered write would be presented, that write is lost: `framebuffer_master` muxes in its own clear writes.
- The block therefore forces `wr1_en`/`wr2_en` to 0 in that cycle and counts each suppressed valid write in `drop_count`.

Counters:
- Both counters clear to 0 on the rising edge of `fb_resetting`.
- A clear takes priority over an increment in the same cycle.
- Two increments in one cycle add 2, saturating.

## Timing
- Acceptance to write-port presentation: 1 cycle. Grant logic is combinational; the output stage is registered.
- Throughput: 2 pixels/cycle when two or more requesters are valid with distinct addresses.
- A single valid requester uses port 1 only; port 2 enable is 0.

Values after reset (`reset` = 0 sampled):
- All enables 0; all addresses and data 0.
- `rr_ptr` = 0; both counters 0.
- `req_ready` = 0 during the reset cycle.

Reset mid-operation:
- Pending output-stage writes are discarded; no enable is asserted the following cycle.
- Requesters must re-present their pixels.

`fb_resetting` edges:
- Rising edge: blocks grants in the same cycle.
- Falling edge: grants resume in the first cycle it is sampled low.

## Structure
- Add `FB_TRANSPARENT` and `FB_ARB_MAX_REQ` to `params.vh` next to the existing framebuffer constants.
- Sub-module `fb_arb_picker`: purely combinational two-grant rotating-priority picker. Inputs: valid vector, pointer and addresses. Outputs: `grant_a`/`grant_b` one-hot vectors and their indices, plus `found_a`/`found_b`.
- The top level holds `rr_ptr`, the output register and the counters.

## Test plan
- **Single requester.** Req0 valid, addr 100, data 5 -> `req_ready[0]` = 1 same cycle; next cycle `wr1_en` = 1, `addr_wr1` = 100, `data_wr1` = 5; `wr2_en` = 0.
- **Round-robin fairness.** All four valid continuously, distinct addresses, `rr_ptr` = 0 -> grants (0,1), (2,3), (0,1) on successive cycles.
- **Same-address conflict.** Req1 and req2 both addr 42 -> only req1 is granted; req2 is granted the next cycle to port 1; no cycle has both enables at addr 42.
- **Transparent and out-of-range.** Data 0 -> accepted with no enable and no counter change. Addr `FRAMEBUFFER_SIZE` -> accepted, no enable, `drop_count` = 1.
- **`fb_resetting` window.**
  - Pixel accepted one cycle before `fb_resetting` rises -> enable suppressed, `drop_count` + 1.
  - `req_ready` stays 0 while `fb_resetting` is high.
  - Both counters read 0 one cycle after the rising edge.
- **Synchronous reset mid-burst.** `reset` = 0 while two grants are in flight -> next cycle both enables 0, `rr_ptr` = 0, counters 0.
